// File: rtl/pixel_readout_serializer.sv
// Pixel readout serializer: snapshots NUM_CH measurement words on a capture strobe and shifts
// them out MSB-first, channel 0 first, one bit per rising edge of an asynchronous readout clock.
// Every output is driven straight from a flop.
module pixel_readout_serializer #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         capture,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic                         rclk,
  input  logic                         overrun_clr,
  output logic                         sdata_out,
  output logic                         frame_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int unsigned TotalBits = NUM_CH * DATA_WIDTH;
  localparam int unsigned CntWidth  = $clog2(TotalBits + 1);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TotalBits - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rclk_dly_q;
  logic                   rclk_rise;
  logic [TotalBits-1:0]   frame_q, frame_d;
  logic [TotalBits-1:0]   capture_frame;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic                   sdata_q, sdata_d;
  logic                   active_q, active_d;
  logic                   overrun_q, overrun_d;
  logic                   last_bit;

  // Synchronise the readout clock and keep one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '0;
      rclk_dly_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rclk};
      rclk_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rclk_rise = sync_q[SYNC_STAGES-1] & ~rclk_dly_q;
  assign last_bit  = (cnt_q == LastCnt);

  // Place channel 0 in the top slot so that a left shift emits ch0 MSB first.
  always_comb begin
    capture_frame = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      capture_frame[(NUM_CH-1-k)*DATA_WIDTH +: DATA_WIDTH] = ch_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: a capture starts a frame, the last consumed bit ends it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (rclk_rise && last_bit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM output logic: next values of the frame register, bit counter and output flops.
  always_comb begin
    frame_d   = frame_q;
    cnt_d     = cnt_q;
    sdata_d   = sdata_q;
    overrun_d = overrun_q;
    unique case (state_q)
      StIdle: begin
        // Readout clock edges in idle are ignored; the pin is held low.
        sdata_d = 1'b0;
        if (capture) begin
          frame_d = capture_frame;
          cnt_d   = '0;
          sdata_d = capture_frame[TotalBits-1];
        end
      end
      StShift: begin
        if (rclk_rise) begin
          cnt_d   = cnt_q + CntWidth'(1);
          frame_d = frame_q << 1;
          // Present the following bit on the same edge that consumes the current one.
          sdata_d = last_bit ? 1'b0 : frame_q[TotalBits-2];
        end
        // A capture during a frame is dropped and flagged; set beats clear.
        if (capture) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        sdata_d = 1'b0;
      end
    endcase
    if (!(capture && (state_q == StShift)) && overrun_clr) begin
      overrun_d = 1'b0;
    end
    active_d = (state_d == StShift);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q   <= '0;
      cnt_q     <= '0;
      sdata_q   <= 1'b0;
      active_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      frame_q   <= frame_d;
      cnt_q     <= cnt_d;
      sdata_q   <= sdata_d;
      active_q  <= active_d;
      overrun_q <= overrun_d;
    end
  end

  assign sdata_out   = sdata_q;
  assign frame_valid = active_q;
  assign busy        = active_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pixel_readout_serializer.sv
// Scoreboard bench for pixel_readout_serializer at default parameters (8 x 16 bits).
module tb_pixel_readout_serializer;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned DW     = 16;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned TOTAL  = NUM_CH * DW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             capture = 1'b0;
  logic [TOTAL-1:0] ch_data = '0;
  logic             rclk = 1'b0;
  logic             overrun_clr = 1'b0;
  logic             sdata_out;
  logic             frame_valid;
  logic             busy;
  logic             overrun;

  pixel_readout_serializer #(
    .NUM_CH      (NUM_CH),
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture     (capture),
    .ch_data     (ch_data),
    .rclk        (rclk),
    .overrun_clr (overrun_clr),
    .sdata_out   (sdata_out),
    .frame_valid (frame_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: queue of bits still owed by the current frame, plus the overrun flag.
  bit   exp_q[$];
  int   last_pop = -100;
  logic exp_ov = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Host-side monitor: sample the pin just before each readout clock rise.
  always @(posedge rclk) begin
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        mon_bit = exp_q.pop_front();
        check("sdata_bit", 32'(sdata_out), 32'(mon_bit));
        check("frame_valid_in_frame", 32'(frame_valid), 32'd1);
        check("busy_in_frame", 32'(busy), 32'd1);
        last_pop = cyc;
      end else begin
        check("sdata_idle", 32'(sdata_out), 32'd0);
        check("frame_valid_idle", 32'(frame_valid), 32'd0);
      end
    end
  end

  function automatic logic [TOTAL-1:0] rand_data();
    logic [TOTAL-1:0] r;
    for (int i = 0; i < int'(TOTAL / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Issue a capture at a negedge; the model decides acceptance from the frame timing.
  task automatic do_capture(input logic [TOTAL-1:0] data, input logic clr);
    bit accepted;
    ch_data     = data;
    capture     = 1'b1;
    overrun_clr = clr;
    // The DUT returns to idle SYNC+1 edges after the rise that consumed the last bit.
    accepted = (exp_q.size() == 0) && (cyc >= last_pop + int'(SYNC) + 1);
    if (accepted) begin
      for (int k = 0; k < int'(NUM_CH); k++)
        for (int b = int'(DW) - 1; b >= 0; b--) exp_q.push_back(data[k*DW + b]);
      if (clr) exp_ov = 1'b0;
    end else begin
      exp_ov = 1'b1;
    end
    @(negedge clk);
    capture     = 1'b0;
    overrun_clr = 1'b0;
    check("overrun_after_capture", 32'(overrun), 32'(exp_ov));
  endtask

  task automatic clear_ov();
    overrun_clr = 1'b1;
    exp_ov      = 1'b0;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("overrun_clear", 32'(overrun), 32'(exp_ov));
  endtask

  task automatic pulse(input int hi, input int lo);
    rclk = 1'b1;
    repeat (hi) @(negedge clk);
    rclk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic rand_pulse();
    pulse(int'($urandom_range(4, 7)), int'($urandom_range(4, 7)));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sdata"}, 32'(sdata_out), 32'd0);
    check({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Clock out whatever the model still expects, bounded by a pulse budget.
  task automatic run_frame();
    int guard = 0;
    while (exp_q.size() > 0 && guard < int'(TOTAL) + 8) begin
      rand_pulse();
      guard++;
    end
    check("frame_drained_in_budget", 32'(exp_q.size()), 32'd0);
    check_idle("after_frame");
  endtask

  // Final pulse of a frame with a capture in either the final-rise cycle or the first idle one.
  task automatic last_pulse_capture(input logic [TOTAL-1:0] data, input bit late);
    rclk = 1'b1;
    repeat (late ? SYNC + 1 : SYNC) @(negedge clk);
    check("busy_at_final_edge", 32'(busy), late ? 32'd0 : 32'd1);
    do_capture(data, 1'b0);
    repeat (2) @(negedge clk);
    rclk = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    exp_ov   = 1'b0;
    last_pop = -100;
    check_idle("reset");
    check("reset_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TOTAL-1:0] d;
    int guard;

    // Reset with the readout clock already high: its first synchronised rise must be ignored.
    rclk = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("por");
    check("por_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_idle("rclk_high_at_release");
    rclk = 1'b0;
    repeat (6) @(negedge clk);
    repeat (3) rand_pulse();
    check_idle("idle_toggling");
    check("idle_overrun", 32'(overrun), 32'd0);

    // First bit one cycle after capture; change exactly SYNC+1 edges after rclk is seen high.
    d = rand_data();
    d[15:0] = 16'hAAAA;
    do_capture(d, 1'b0);
    check("first_bit", 32'(sdata_out), 32'd1);
    check("first_frame_valid", 32'(frame_valid), 32'd1);
    check("first_busy", 32'(busy), 32'd1);
    rclk = 1'b1;
    @(negedge clk) check("latency_edge1", 32'(sdata_out), 32'd1);
    @(negedge clk) check("latency_edge2", 32'(sdata_out), 32'd1);
    @(negedge clk) check("latency_edge3", 32'(sdata_out), 32'd0);
    repeat (3) @(negedge clk);
    rclk = 1'b0;
    repeat (6) @(negedge clk);
    run_frame();

    // Capture mid-frame is dropped; overrun is sticky, clearable, and set beats clear.
    do_capture(rand_data(), 1'b0);
    repeat (5) rand_pulse();
    do_capture({TOTAL{1'b1}}, 1'b0);
    repeat (3) rand_pulse();
    check("overrun_sticky", 32'(overrun), 32'd1);
    clear_ov();
    do_capture(rand_data(), 1'b1);
    ch_data = rand_data();
    run_frame();
    clear_ov();

    // Reset mid-frame aborts it; later readout edges emit nothing; a fresh frame works.
    do_capture(rand_data(), 1'b0);
    repeat (7) rand_pulse();
    do_reset();
    repeat (3) rand_pulse();
    d = rand_data();
    d[15:0] = 16'h0180;
    do_capture(d, 1'b0);
    run_frame();

    // Incrementing words; frame ends on exactly the 128th rise; back-to-back capture accepted.
    for (int k = 0; k < int'(NUM_CH); k++) d[k*DW +: DW] = 16'(k + 1);
    do_capture(d, 1'b0);
    guard = 0;
    while (exp_q.size() > 1 && guard < int'(TOTAL)) begin
      rand_pulse();
      guard++;
    end
    check("busy_before_last_bit", 32'(busy), 32'd1);
    last_pulse_capture(rand_data(), 1'b1);
    check("back_to_back_busy", 32'(busy), 32'd1);
    run_frame();

    // Capture landing on the final rise cycle is still an overrun.
    do_capture(rand_data(), 1'b0);
    guard = 0;
    while (exp_q.size() > 1 && guard < int'(TOTAL)) begin
      rand_pulse();
      guard++;
    end
    last_pulse_capture(rand_data(), 1'b0);
    run_frame();
    clear_ov();

    // Randomised frames with stray captures, clears and input churn.
    repeat (3) begin
      do_capture(rand_data(), 1'($urandom_range(0, 1)));
      guard = 0;
      while (exp_q.size() > 0 && guard < int'(TOTAL) + 8) begin
        rand_pulse();
        guard++;
        if ($urandom_range(0, 3) == 0) ch_data = rand_data();
        if ($urandom_range(0, 15) == 0) do_capture(rand_data(), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 31) == 0) clear_ov();
      end
      run_frame();
      check("random_overrun", 32'(overrun), 32'(exp_ov));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_readout_serializer.md
Name: pixel_readout_serializer

Overview:
- Output-side counterpart to the row/column shift-register loaders. Those shift pixel data in on an external RCLK/DATA_IN pin pair; this block shifts measurement results out.
- Snapshots NUM_CH parallel measurement words (e.g. frequency_counter PERIOD values) on a CAPTURE strobe. Serialises them MSB-first onto one output pin, one bit per rising edge of an externally driven readout clock.
- Sits between the frequency_counter array and the chip output pins.

Parameters:
- NUM_CH, 8, number of measurement channels per frame.
- DATA_WIDTH, 16, bits per channel word.
- SYNC_STAGES, 2, synchroniser flops on RCLK (minimum 2).

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RST_N  input  1  synchronous, active-low reset.
- CAPTURE  input  1  single-cycle strobe; snapshot CH_DATA and start a frame.
- CH_DATA  input  NUM_CH*DATA_WIDTH  channel words; channel k = CH_DATA[k*DATA_WIDTH +: DATA_WIDTH].
- RCLK  input  1  external readout clock, asynchronous to CLK.
- OVERRUN_CLR  input  1  clears OVERRUN.
- SDATA_OUT  output  1  serial data bit.
- FRAME_VALID  output  1  high while a frame is being shifted out.
- BUSY  output  1  high from the cycle after an accepted CAPTURE until the frame ends.
- OVERRUN  output  1  sticky; a CAPTURE arrived while BUSY.

Behaviour:
- Reset (RST_N low at a CLK edge): state IDLE; SDATA_OUT=0, FRAME_VALID=0, BUSY=0, OVERRUN=0. Synchroniser and edge-detect flops cleared to 0; bit counter 0; frame register 0. Reset mid-frame aborts the frame immediately with no further bits.
- RCLK path: SYNC_STAGES flop chain, then one delay flop. rclk_rise = sync_out & ~delayed.
  - SDATA_OUT advances on the (SYNC_STAGES+1)th CLK edge after RCLK is first sampled high.
  - Host constraints: RCLK high and low phases each >= SYNC_STAGES+2 CLK periods. Host samples SDATA_OUT just before each RCLK rising edge.
- State IDLE:
  - Outputs 0 except OVERRUN.
  - rclk_rise is ignored. This covers RCLK already high when reset is released.
  - On CAPTURE: load frame register with channel 0 word first, MSB first; i.e. bit order ch0[DW-1]..ch0[0], ch1[DW-1].. and so on. Clear bit counter. Go to SHIFT.
  - On the next cycle, SDATA_OUT = ch0[DW-1] and FRAME_VALID=BUSY=1.
- State SHIFT:
  - Each rclk_rise consumes the current bit. Bit counter increments; SDATA_OUT presents the next bit on the same edge.
  - On the rclk_rise with counter = NUM_CH*DATA_WIDTH-1 (last bit consumed): go to IDLE. On that edge SDATA_OUT=0, FRAME_VALID=0, BUSY=0.
  - Total bits per frame = NUM_CH*DATA_WIDTH. Counter width = clog2(NUM_CH*DATA_WIDTH+1). No wrap within a frame.
- CAPTURE while in SHIFT (including the cycle of the final rclk_rise): ignored; frame register untouched; OVERRUN set to 1.
- A CAPTURE in the first IDLE cycle after a frame ends is accepted normally.
- OVERRUN: set has priority over OVERRUN_CLR on the same cycle; otherwise OVERRUN_CLR clears it on the next edge.
- CH_DATA is sampled only on an accepted CAPTURE. Changes during SHIFT have no effect.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan:
- Reset, then drive RCLK toggling with no CAPTURE. Required: SDATA_OUT, FRAME_VALID, BUSY and OVERRUN all stay 0.
- NUM_CH=2, DATA_WIDTH=8, CH_DATA=16'h3CA5, CAPTURE pulse, then 16 RCLK pulses (high 6 / low 6 CLK). Required sampled stream: 1010_0101_0011_1100. FRAME_VALID and BUSY drop on the 16th synchronised edge; SDATA_OUT=0 afterward.
- Same config, measure latency. Required: SDATA_OUT changes exactly SYNC_STAGES+1 (3) CLK edges after RCLK is first sampled high. First bit is valid 1 cycle after CAPTURE.
- CAPTURE again after 5 bits with CH_DATA changed to 16'hFFFF. Required: stream continues with the original 16'h3CA5 bits; OVERRUN=1 and stays 1. OVERRUN_CLR then gives OVERRUN=0 on the next edge. CAPTURE and OVERRUN_CLR together give OVERRUN=1.
- RST_N low for 1 cycle after 7 bits. Required: all outputs 0 on the next edge. Subsequent RCLK edges produce no bits. A new CAPTURE of 16'h0180 yields stream 1000_0000_0000_0001.
- Default parameters (8x16) with incrementing channel words 16'h0001..16'h0008. Required: 128 bits, ch0 first. Frame ends after exactly 128 rclk_rise events. A back-to-back CAPTURE on the first IDLE cycle is accepted with OVERRUN=0.
